adder_sum_accumulator: RTL and testbench

ADDER_SUM_ACCUMULATOR -- requirements
Module: adder_sum_accumulator

---
 rtl/adder_sum_accumulator_pkg.sv | 13 +
 rtl/adder_sum_accumulator_sat_add.sv | 25 ++
 rtl/adder_sum_accumulator.sv | 101 ++++++++++
 tb/tb_adder_sum_accumulator.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_sum_accumulator_pkg.sv
// Shared definitions for the adder-sum accumulation slice.
// Holds the sum width, the default accumulator width and the FSM state encoding.
package adder_pkg;

   localparam int unsigned SUM_W     = 33;
   localparam int unsigned ACC_W_DEF = 40;

   typedef logic [0:0] state_t;

   localparam state_t ACCUM = 1'b0;
   localparam state_t DONE  = 1'b1;

endpackage

// File: rtl/adder_sum_accumulator_sat_add.sv
// Combinational signed two's-complement adder that clamps to the representable
// range of W bits and flags when a clamp happened.
module sat_add #(
   parameter int unsigned W = 40
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y,
   output logic         ovf
);

   logic [W-1:0] raw;

   always_comb begin
      raw = a + b;
      // Overflow only when both operands share a sign that the raw result lost.
      ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
      if (ovf) begin
         y = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
         y = raw;
      end
   end

endmodule

// File: rtl/adder_sum_accumulator.sv
// Accumulates N_SAMPLES signed 33-bit sums into a saturating window total and
// presents the result through a valid/ready handshake.
module adder_sum_accumulator
   import adder_pkg::*;
#(
   parameter int unsigned N_SAMPLES = 8,
   parameter int unsigned ACC_W     = ACC_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SUM_W-1:0]        in_sum,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ACC_W-1:0]        out_total,
   output logic [7:0]              out_count,
   output logic                    out_sat
);

   state_t            state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              sat_q, sat_d;
   logic              rdy_en_q, rdy_en_d;

   logic [ACC_W-1:0]  ext_sum;
   logic [ACC_W-1:0]  acc_next;
   logic              acc_ovf;
   logic              accept;

   assign ext_sum = {{(ACC_W-SUM_W){in_sum[SUM_W-1]}}, in_sum};

   sat_add #(.W(ACC_W)) u_sat_add (
      .a   (acc_q),
      .b   (ext_sum),
      .y   (acc_next),
      .ovf (acc_ovf)
   );

   // rdy_en_q keeps in_ready low until the first edge after reset release.
   assign in_ready  = rdy_en_q && (state_q == ACCUM) && !clear;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign out_total = acc_q;
   assign out_count = cnt_q;
   assign out_sat   = sat_q;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sat_d    = sat_q;
      rdy_en_d = 1'b1;
      if (clear) begin
         state_d = ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
         sat_d   = 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (accept) begin
                  acc_d = acc_next;
                  cnt_d = cnt_q + 8'd1;
                  sat_d = sat_q | acc_ovf;
                  if (cnt_q == 8'(N_SAMPLES - 1)) begin
                     state_d = DONE;
                  end
               end
            end
            default: begin
               if (out_ready) begin
                  state_d = ACCUM;
                  acc_d   = '0;
                  cnt_d   = '0;
                  sat_d   = 1'b0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ACCUM;
         acc_q    <= '0;
         cnt_q    <= '0;
         sat_q    <= 1'b0;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sat_q    <= sat_d;
         rdy_en_q <= rdy_en_d;
      end
   end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed bench for adder_sum_accumulator with a queue of expected window results.
module tb_adder_sum_accumulator;

   logic clk;
   logic rst_n;
   logic clear;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sat;
   logic [32:0] a_in_sum;
   logic [39:0] a_out_total;
   logic [7:0]  a_out_count;

   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_sat;
   logic [32:0] s_in_sum;
   logic [33:0] s_out_total;
   logic [7:0]  s_out_count;

   logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_out_sat;
   logic [32:0] n_in_sum;
   logic [39:0] n_out_total;
   logic [7:0]  n_out_count;

   typedef struct {
      longint total;
      int     count;
      bit     sat;
   } exp_t;

   exp_t sb[$];
   int   total;
   int   bad;

   adder_sum_accumulator #(.N_SAMPLES(8), .ACC_W(40)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sum(a_in_sum),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_total(a_out_total), .out_count(a_out_count), .out_sat(a_out_sat)
   );

   adder_sum_accumulator #(.N_SAMPLES(3), .ACC_W(34)) dut_s (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_sum(s_in_sum),
      .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_total(s_out_total), .out_count(s_out_count), .out_sat(s_out_sat)
   );

   adder_sum_accumulator #(.N_SAMPLES(4), .ACC_W(40)) dut_n (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(n_in_valid), .in_ready(n_in_ready), .in_sum(n_in_sum),
      .out_valid(n_out_valid), .out_ready(n_out_ready),
      .out_total(n_out_total), .out_count(n_out_count), .out_sat(n_out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic sb_check(input string tag, input longint tot, input int cnt, input bit sat);
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s observed=output expected=no output (scoreboard empty)", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_total"}, tot, e.total);
         chk({tag, "_count"}, longint'(cnt), longint'(e.count));
         chk({tag, "_sat"}, longint'(sat), longint'(e.sat));
      end
   endtask

   task automatic idle();
      a_in_valid = 1'b0;
      s_in_valid = 1'b0;
      n_in_valid = 1'b0;
   endtask

   // Drive one sum to the selected instance, then advance past one rising edge.
   task automatic send(input int which, input logic [32:0] v);
      idle();
      case (which)
         0: begin a_in_valid = 1'b1; a_in_sum = v; end
         1: begin s_in_valid = 1'b1; s_in_sum = v; end
         default: begin n_in_valid = 1'b1; n_in_sum = v; end
      endcase
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      longint base;
      total = 0;
      bad   = 0;
      rst_n = 1'b1;
      clear = 1'b0;
      a_in_sum = '0; s_in_sum = '0; n_in_sum = '0;
      a_out_ready = 1'b1; s_out_ready = 1'b1; n_out_ready = 1'b1;
      idle();

      // Reset state, then in_ready must stay low until the first edge after release.
      #1 rst_n = 1'b0;
      #2;
      chk("rst_out_valid", longint'(a_out_valid), 0);
      chk("rst_in_ready", longint'(a_in_ready), 0);
      chk("rst_total", longint'($signed(a_out_total)), 0);
      chk("rst_count", longint'(a_out_count), 0);
      #9 rst_n = 1'b1;
      #1;
      chk("rel_in_ready_low", longint'(a_in_ready), 0);
      @(negedge clk);
      chk("rel_in_ready_high", longint'(a_in_ready), 1);

      // Basic window 1..8 with live value check after three accepts.
      for (int i = 1; i <= 8; i++) begin
         if (i == 8) sb.push_back('{36, 8, 1'b0});
         send(0, 33'(i));
         if (i == 3) begin
            chk("live_count", longint'(a_out_count), 3);
            chk("live_total", longint'($signed(a_out_total)), 6);
            chk("live_out_valid", longint'(a_out_valid), 0);
         end
      end
      idle();
      chk("basic_latency", longint'(a_out_valid), 1);
      sb_check("basic", longint'($signed(a_out_total)), int'(a_out_count), a_out_sat);
      @(negedge clk);
      chk("basic_next_valid", longint'(a_out_valid), 0);
      chk("basic_next_total", longint'($signed(a_out_total)), 0);
      chk("basic_next_count", longint'(a_out_count), 0);

      // Backpressure: result held for five cycles, inputs refused throughout.
      a_out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         if (i == 8) sb.push_back('{108, 8, 1'b0});
         send(0, 33'(3 * i));
      end
      sb_check("bp", longint'($signed(a_out_total)), int'(a_out_count), a_out_sat);
      for (int c = 0; c < 5; c++) begin
         a_in_valid = 1'b1;
         a_in_sum   = 33'd99;
         #1;
         chk("bp_in_ready", longint'(a_in_ready), 0);
         @(negedge clk);
         chk("bp_out_valid", longint'(a_out_valid), 1);
         chk("bp_total_hold", longint'($signed(a_out_total)), 108);
         chk("bp_count_hold", longint'(a_out_count), 8);
      end
      a_out_ready = 1'b1;
      @(negedge clk);
      idle();
      chk("bp_closed_valid", longint'(a_out_valid), 0);
      chk("bp_no_accept", longint'(a_out_count), 0);

      // Clear after the third accept, with a sum presented in the same cycle.
      send(0, 33'd5);
      send(0, 33'd6);
      send(0, 33'd7);
      a_in_valid = 1'b1;
      a_in_sum   = 33'd100;
      clear      = 1'b1;
      #1;
      chk("clr_in_ready", longint'(a_in_ready), 0);
      @(negedge clk);
      clear = 1'b0;
      idle();
      chk("clr_count", longint'(a_out_count), 0);
      chk("clr_total", longint'($signed(a_out_total)), 0);
      for (int i = 1; i <= 8; i++) begin
         if (i == 8) sb.push_back('{16, 8, 1'b0});
         send(0, 33'd2);
      end
      idle();
      chk("clr_latency", longint'(a_out_valid), 1);
      sb_check("clr", longint'($signed(a_out_total)), int'(a_out_count), a_out_sat);
      @(negedge clk);

      // Asynchronous reset pulse between edges, mid-window.
      for (int i = 1; i <= 4; i++) send(0, 33'(i));
      idle();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", longint'(a_out_count), 0);
      chk("arst_total", longint'($signed(a_out_total)), 0);
      chk("arst_in_ready", longint'(a_in_ready), 0);
      chk("arst_out_valid", longint'(a_out_valid), 0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("arst_ready_back", longint'(a_in_ready), 1);
      for (int i = 1; i <= 7; i++) send(0, 33'(10 * i));
      idle();
      chk("arst_no_early_valid", longint'(a_out_valid), 0);
      chk("arst_fresh_count", longint'(a_out_count), 7);
      sb.push_back('{360, 8, 1'b0});
      send(0, 33'd80);
      idle();
      chk("arst_latency", longint'(a_out_valid), 1);
      sb_check("arst", longint'($signed(a_out_total)), int'(a_out_count), a_out_sat);
      @(negedge clk);

      // Saturation on a 34-bit accumulator: three sums of 2^32-1.
      base = (longint'(1) <<< 33) - 1;
      for (int i = 1; i <= 3; i++) begin
         if (i == 3) sb.push_back('{base, 3, 1'b1});
         send(1, 33'h0_FFFF_FFFF);
      end
      idle();
      chk("sat_latency", longint'(s_out_valid), 1);
      sb_check("sat", longint'($signed(s_out_total)), int'(s_out_count), s_out_sat);
      @(negedge clk);
      chk("sat_cleared", longint'(s_out_sat), 0);
      send(1, 33'd1);
      idle();
      chk("sat_next_sat", longint'(s_out_sat), 0);
      chk("sat_next_total", longint'($signed(s_out_total)), 1);

      // Alternating negative/positive extremes over a 4-sum window.
      for (int i = 1; i <= 4; i++) begin
         if (i == 4) sb.push_back('{-2, 4, 1'b0});
         send(2, (i % 2 == 1) ? 33'h1_0000_0000 : 33'h0_FFFF_FFFF);
         if (i == 1) chk("neg_min_ext", longint'($signed(n_out_total)), -(longint'(1) <<< 32));
      end
      idle();
      chk("neg_latency", longint'(n_out_valid), 1);
      sb_check("neg", longint'($signed(n_out_total)), int'(n_out_count), n_out_sat);
      @(negedge clk);

      chk("sb_drained", longint'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
